// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: assembles start/8 data/odd parity/stop frames
// sampled on negclk strobes and reports each byte or error with a one-cycle strobe.
module ps2_frame_rx #(
   parameter int TIMEOUT_CYC = 100000,
   parameter int TO_W        = 17
) (
   input  logic       posclk,
   input  logic       reset,
   input  logic       negclk,
   input  logic       kbdata,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       timeout_err,
   output logic       busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 1);

   // Same two-cycle delay as the upstream edge detector keeps bits aligned with negclk.
   logic [1:0] sync_q;
   logic       kbdata_s;

   always_ff @(posedge posclk) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], kbdata};
   end

   assign kbdata_s = sync_q[1];

   state_t          state, state_n;
   logic [3:0]      bit_cnt, bit_cnt_n;
   logic [8:0]      shreg, shreg_n;
   logic [TO_W-1:0] wd, wd_n;
   logic [7:0]      data_n;
   logic            valid_n, perr_n, ferr_n, to_n;

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      wd_n      = '0;
      data_n    = data_out;
      valid_n   = 1'b0;
      perr_n    = 1'b0;
      ferr_n    = 1'b0;
      to_n      = 1'b0;

      case (state)
         IDLE: begin
            if (negclk && !kbdata_s) begin
               state_n   = RECV;
               bit_cnt_n = '0;
            end
         end
         RECV: begin
            if (negclk) begin
               if (bit_cnt == 4'd9) begin
                  // shreg now holds {parity, data[7:0]}; kbdata_s is the stop bit.
                  state_n   = IDLE;
                  bit_cnt_n = '0;
                  if (!(^shreg))     perr_n = 1'b1;
                  else if (!kbdata_s) ferr_n = 1'b1;
                  else begin
                     valid_n = 1'b1;
                     data_n  = shreg[7:0];
                  end
               end else begin
                  // LSB arrives first, so after nine shifts it lands in bit 0.
                  shreg_n   = {kbdata_s, shreg[8:1]};
                  bit_cnt_n = 4'(bit_cnt + 4'd1);
               end
            end else if (wd == WD_LAST) begin
               state_n   = IDLE;
               bit_cnt_n = '0;
               to_n      = 1'b1;
            end else begin
               wd_n = TO_W'(wd + 1'b1);
            end
         end
         default: begin
            state_n   = IDLE;
            bit_cnt_n = '0;
         end
      endcase
   end

   always_ff @(posedge posclk) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         wd          <= '0;
         data_out    <= 8'h00;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         shreg       <= shreg_n;
         wd          <= wd_n;
         data_out    <= data_n;
         data_valid  <= valid_n;
         parity_err  <= perr_n;
         frame_err   <= ferr_n;
         timeout_err <= to_n;
         busy        <= (state_n == RECV);
      end
   end

endmodule
